// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU op sequencer.
// Modes, ALU function codes, flag indices and FSM states.
package alu_seq_pkg;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_MUL    = 2'b01;
  localparam logic [1:0] MODE_ACC    = 2'b10;
  localparam logic [1:0] MODE_CLR    = 2'b11;

  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0001;
  localparam logic [3:0] FN_AND  = 4'b0100;
  localparam logic [3:0] FN_OR   = 4'b0101;
  localparam logic [3:0] FN_XOR  = 4'b0110;
  localparam logic [3:0] FN_SLL  = 4'b1000;
  localparam logic [3:0] FN_SRL  = 4'b1001;
  localparam logic [3:0] FN_SRA  = 4'b1010;
  localparam logic [3:0] FN_PASS = 4'b1111;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EXEC      = 3'd1,
    S_MUL_ADD   = 3'd2,
    S_MUL_SHIFT = 3'd3,
    S_RESP      = 3'd4
  } state_t;

endpackage

// File: rtl/alu_seq_mul_reg.sv
// Shift-add multiply datapath: {cy,hi,lo} register,
// multiplicand and step counter, sequenced by the FSM.
module alu_seq_mul_reg
  import alu_seq_pkg::*;
#(
  parameter int MUL_STEPS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       add_cap,
  input  logic       shift,
  input  logic [3:0] mcand_in,
  input  logic [3:0] mplier_in,
  input  logic [3:0] alu_y,
  input  logic       alu_c,
  output logic [3:0] mcand,
  output logic [3:0] hi_next,
  output logic [7:0] prod_next,
  output logic       last
);

  logic       cy;
  logic [3:0] hi;
  logic [3:0] lo;
  logic [2:0] cnt;

  // Load, conditional add capture, then a right shift per step
  always_ff @(posedge clk) begin
    if (reset) begin
      cy    <= 1'b0;
      hi    <= 4'h0;
      lo    <= 4'h0;
      mcand <= 4'h0;
      cnt   <= 3'd0;
    end else if (load) begin
      cy    <= 1'b0;
      hi    <= 4'h0;
      lo    <= mplier_in;
      mcand <= mcand_in;
      cnt   <= 3'(MUL_STEPS);
    end else if (add_cap) begin
      if (lo[0]) begin
        cy <= alu_c;
        hi <= alu_y;
      end else begin
        cy <= 1'b0;
      end
    end else if (shift) begin
      cy  <= 1'b0;
      hi  <= {cy, hi[3:1]};
      lo  <= {hi[0], lo[3:1]};
      cnt <= cnt - 3'd1;
    end
  end

  assign hi_next   = {cy, hi[3:1]};
  assign prod_next = {cy, hi, lo[3:1]};
  assign last      = (cnt == 3'd1);

endmodule

// File: rtl/alu_op_sequencer.sv
// Command FSM driving an external 4-bit ALU over one
// or more cycles; single/acc/clr ops and 4x4 multiply.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MUL_STEPS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [3:0] cmd_func,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_func,
  input  logic [3:0] alu_y,
  input  logic [3:0] alu_flags,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_flags,
  output logic [3:0] acc
);

  state_t     state;
  logic       is_acc;
  logic       accept;
  logic       mul_load;
  logic [3:0] mcand;
  logic [3:0] hi_next;
  logic [7:0] prod_next;
  logic       last;

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign mul_load  = accept && (cmd_mode == MODE_MUL);

  alu_seq_mul_reg #(
    .MUL_STEPS(MUL_STEPS)
  ) u_mul (
    .clk      (clk),
    .reset    (reset),
    .load     (mul_load),
    .add_cap  (state == S_MUL_ADD),
    .shift    (state == S_MUL_SHIFT),
    .mcand_in (cmd_a),
    .mplier_in(cmd_b),
    .alu_y    (alu_y),
    .alu_c    (alu_flags[FLAG_C]),
    .mcand    (mcand),
    .hi_next  (hi_next),
    .prod_next(prod_next),
    .last     (last)
  );

  // Main sequencer: ALU operand regs, response and accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      is_acc    <= 1'b0;
      alu_a     <= 4'h0;
      alu_b     <= 4'h0;
      alu_func  <= FN_PASS;
      rsp_data  <= 8'h00;
      rsp_flags <= 4'h0;
      acc       <= 4'h0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            is_acc <= (cmd_mode == MODE_ACC);
            unique case (cmd_mode)
              MODE_SINGLE: begin
                alu_a    <= cmd_a;
                alu_b    <= cmd_b;
                alu_func <= cmd_func;
                state    <= S_EXEC;
              end
              MODE_ACC: begin
                alu_a    <= acc;
                alu_b    <= cmd_b;
                alu_func <= cmd_func;
                state    <= S_EXEC;
              end
              MODE_CLR: begin
                acc       <= 4'h0;
                rsp_data  <= 8'h00;
                rsp_flags <= 4'b1000;
                state     <= S_RESP;
              end
              MODE_MUL: begin
                alu_a    <= 4'h0;
                alu_b    <= cmd_a;
                alu_func <= FN_ADD;
                state    <= S_MUL_ADD;
              end
            endcase
          end
        end
        S_EXEC: begin
          rsp_data  <= {4'h0, alu_y};
          rsp_flags <= alu_flags;
          if (is_acc) acc <= alu_y;
          alu_a    <= 4'h0;
          alu_b    <= 4'h0;
          alu_func <= FN_PASS;
          state    <= S_RESP;
        end
        S_MUL_ADD: begin
          state <= S_MUL_SHIFT;
        end
        S_MUL_SHIFT: begin
          if (last) begin
            rsp_data  <= prod_next;
            rsp_flags <= {prod_next == 8'h00,
                          prod_next[7], 2'b00};
            alu_a    <= 4'h0;
            alu_b    <= 4'h0;
            alu_func <= FN_PASS;
            state    <= S_RESP;
          end else begin
            alu_a <= hi_next;
            alu_b <= mcand;
            state <= S_MUL_ADD;
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
